// File: rtl/data_mem_lsu_if.sv
// Request/response handshake between the MIPS datapath and the load/store unit.
interface data_mem_lsu_if #(parameter int unsigned ADDR_W = 10);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_lsu.sv
// Load/store unit for the single-port datamemory: byte/halfword/word access,
// sub-word stores via read-modify-write. LSU_MISALIGN_TRAP_EN rejects misaligned/reserved accesses.
module data_mem_lsu #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_lsu_if.slave     bus,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       dataIn,
  output logic              we,
  input  logic [31:0]       dataOut
);

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  state_t      state, state_nx;
  logic        wr_q, uns_q, err_q;
  logic [1:0]  size_q, off_q;
  logic [31:0] wdata_q;
  logic        reject;
  logic [31:0] merged, load_data;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    reject = (bus.req_size == 2'b11) ||
             (bus.req_size == 2'b01 && bus.req_addr[0]) ||
             (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
`else
    reject = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // address is only reloaded on acceptance so dataOut stays stable through RSP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      address <= '0;
    end else if (state == IDLE && bus.req_valid) begin
      wr_q    <= bus.req_write;
      uns_q   <= bus.req_unsigned;
      err_q   <= reject;
      size_q  <= bus.req_size;
      off_q   <= bus.req_addr[1:0];
      wdata_q <= bus.req_wdata;
      address <= bus.req_addr[ADDR_W+1:2];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.req_valid) begin
        if (reject)                            state_nx = RSP;
        else if (bus.req_write && bus.req_size[1]) state_nx = WR;
        else                                   state_nx = RD;
      end
      RD:      state_nx = wr_q ? WR : RSP;
      WR:      state_nx = RSP;
      RSP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Size 11 falls into the word path whenever it is not rejected
  always_comb begin
    merged = dataOut;
    if (size_q[1])
      merged = wdata_q;
    else if (size_q[0]) begin
      if (off_q[1]) merged[31:16] = wdata_q[15:0];
      else          merged[15:0]  = wdata_q[15:0];
    end else
      merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
  end

  always_comb begin
    lane_b = dataOut[{off_q, 3'b000} +: 8];
    lane_h = off_q[1] ? dataOut[31:16] : dataOut[15:0];
    if (size_q[1])
      load_data = dataOut;
    else if (size_q[0])
      load_data = {{16{~uns_q & lane_h[15]}}, lane_h};
    else
      load_data = {{24{~uns_q & lane_b[7]}}, lane_b};
  end

  always_comb begin
    we            = (state == WR);
    dataIn        = we ? merged : '0;
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == RSP);
    bus.rsp_rdata = (state == RSP && !wr_q && !err_q) ? load_data : '0;
`ifdef LSU_MISALIGN_TRAP_EN
    bus.rsp_err   = (state == RSP) && err_q;
`else
    bus.rsp_err   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu with a registered-read word memory model.
module tb_data_mem_lsu;
  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] address;
  logic [31:0]       dataIn;
  logic              we;
  logic [31:0]       dataOut = '0;

  logic [31:0]       mem [0:1023];
  logic              pl_en = 1'b0;
  logic [9:0]        pl_addr = '0;
  logic [31:0]       pl_data = '0;
  int                cyc = 0;
  int                n_cmp = 0;
  int                n_bad = 0;

  data_mem_lsu_if #(.ADDR_W(ADDR_W)) bus ();

  data_mem_lsu #(.ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .address (address),
    .dataIn  (dataIn),
    .we      (we),
    .dataOut (dataOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_en)   mem[pl_addr] <= pl_data;
    else if (we) mem[address] <= dataIn;
    dataOut <= mem[address];
  end

  task automatic set_word(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Drives one request and reports what the unit did; lat = -1 on timeout
  task automatic issue(input logic w, input logic [1:0] sz, input logic un,
                       input logic [11:0] a, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic er,
                       output int wec, output int dinbad, output int rc);
    int waited;
    lat = -1; rd = 'x; er = 'x; wec = 0; dinbad = 0; rc = -1; waited = 0;
    @(negedge clk);
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) return;
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
    bus.req_unsigned = un; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (we) wec++;
      if (!we && dataIn !== '0) dinbad++;
      if (bus.rsp_valid) begin
        lat = k; rd = bus.rsp_rdata; er = bus.rsp_err; rc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", bus.rsp_rdata); end
    n_cmp++; if (bus.rsp_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", bus.rsp_err); end
    n_cmp++; if (address !== 10'd0) begin n_bad++; $display("FAIL rst_address: got %0d want 0", address); end
    n_cmp++; if (dataIn !== 32'h0) begin n_bad++; $display("FAIL rst_dataIn: got %h want 0", dataIn); end
    n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", we); end
    rst = 1'b0;
  endtask

  task automatic test_word_store_load();
    int lat, wec, db, rc; logic [31:0] rd; logic er;
    issue(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, lat, rd, er, wec, db, rc);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL ws_lat: got %0d want 2", lat); end
    n_cmp++; if (wec !== 1) begin n_bad++; $display("FAIL ws_we_cycles: got %0d want 1", wec); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL ws_rdata: got %h want 0", rd); end
    n_cmp++; if (mem[4] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ws_mem4: got %h want deadbeef", mem[4]); end
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, lat, rd, er, wec, db, rc);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wl_lat: got %0d want 2", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wl_rdata: got %h want deadbeef", rd); end
    n_cmp++; if (wec !== 0) begin n_bad++; $display("FAIL wl_we_cycles: got %0d want 0", wec); end
    @(negedge clk);
    n_cmp++; if (address !== 10'd4) begin n_bad++; $display("FAIL wl_address_hold: got %0d want 4", address); end
  endtask

  task automatic test_subword_store();
    int lat, wec, db, rc; logic [31:0] rd; logic er;
    set_word(10'd4, 32'h11223344);
    issue(1'b1, 2'b00, 1'b0, 12'h012, 32'hFFFFFFAA, lat, rd, er, wec, db, rc);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL sb_lat: got %0d want 3", lat); end
    n_cmp++; if (wec !== 1) begin n_bad++; $display("FAIL sb_we_cycles: got %0d want 1", wec); end
    n_cmp++; if (db !== 0) begin n_bad++; $display("FAIL sb_dataIn_idle: got %0d want 0", db); end
    n_cmp++; if (mem[4] !== 32'h11AA3344) begin n_bad++; $display("FAIL sb_mem4: got %h want 11aa3344", mem[4]); end
    set_word(10'd4, 32'h11223344);
    issue(1'b1, 2'b01, 1'b0, 12'h012, 32'hABCD5566, lat, rd, er, wec, db, rc);
    n_cmp++; if (mem[4] !== 32'h55663344) begin n_bad++; $display("FAIL sh_hi_mem4: got %h want 55663344", mem[4]); end
    set_word(10'd4, 32'h11223344);
    issue(1'b1, 2'b01, 1'b0, 12'h010, 32'h00005566, lat, rd, er, wec, db, rc);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL sh_lo_lat: got %0d want 3", lat); end
    n_cmp++; if (mem[4] !== 32'h11225566) begin n_bad++; $display("FAIL sh_lo_mem4: got %h want 11225566", mem[4]); end
    set_word(10'd4, 32'h11223344);
    issue(1'b1, 2'b00, 1'b0, 12'h013, 32'h00000077, lat, rd, er, wec, db, rc);
    n_cmp++; if (mem[4] !== 32'h77223344) begin n_bad++; $display("FAIL sb3_mem4: got %h want 77223344", mem[4]); end
  endtask

  task automatic test_extension();
    int lat, wec, db, rc; logic [31:0] rd; logic er;
    set_word(10'd5, 32'h0000F080);
    issue(1'b0, 2'b00, 1'b0, 12'h014, 32'h0, lat, rd, er, wec, db, rc);
    n_cmp++; if (rd !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_s: got %h want ffffff80", rd); end
    issue(1'b0, 2'b00, 1'b1, 12'h014, 32'h0, lat, rd, er, wec, db, rc);
    n_cmp++; if (rd !== 32'h00000080) begin n_bad++; $display("FAIL lb_u: got %h want 00000080", rd); end
    issue(1'b0, 2'b01, 1'b0, 12'h014, 32'h0, lat, rd, er, wec, db, rc);
    n_cmp++; if (rd !== 32'hFFFFF080) begin n_bad++; $display("FAIL lh_s: got %h want fffff080", rd); end
    issue(1'b0, 2'b01, 1'b1, 12'h014, 32'h0, lat, rd, er, wec, db, rc);
    n_cmp++; if (rd !== 32'h0000F080) begin n_bad++; $display("FAIL lh_u: got %h want 0000f080", rd); end
    issue(1'b0, 2'b00, 1'b0, 12'h015, 32'h0, lat, rd, er, wec, db, rc);
    n_cmp++; if (rd !== 32'hFFFFFFF0) begin n_bad++; $display("FAIL lb1_s: got %h want fffffff0", rd); end
    set_word(10'd5, 32'h80F00000);
    issue(1'b0, 2'b01, 1'b0, 12'h016, 32'h0, lat, rd, er, wec, db, rc);
    n_cmp++; if (rd !== 32'hFFFF80F0) begin n_bad++; $display("FAIL lh2_s: got %h want ffff80f0", rd); end
    issue(1'b0, 2'b00, 1'b1, 12'h017, 32'h0, lat, rd, er, wec, db, rc);
    n_cmp++; if (rd !== 32'h00000080) begin n_bad++; $display("FAIL lb3_u: got %h want 00000080", rd); end
  endtask

  task automatic test_wrap();
    int lat, wec, db, rc; logic [31:0] rd; logic er;
    issue(1'b1, 2'b10, 1'b0, 12'hFFC, 32'h12345678, lat, rd, er, wec, db, rc);
    n_cmp++; if (mem[1023] !== 32'h12345678) begin n_bad++; $display("FAIL wrap_mem: got %h want 12345678", mem[1023]); end
    issue(1'b0, 2'b10, 1'b0, 12'hFFC, 32'h0, lat, rd, er, wec, db, rc);
    n_cmp++; if (rd !== 32'h12345678) begin n_bad++; $display("FAIL wrap_rdata: got %h want 12345678", rd); end
    n_cmp++; if (address !== 10'd1023) begin n_bad++; $display("FAIL wrap_address: got %0d want 1023", address); end
  endtask

  task automatic test_misalign();
    int lat, wec, db, rc; logic [31:0] rd; logic er;
    set_word(10'd4, 32'hCAFEF00D);
    issue(1'b0, 2'b10, 1'b0, 12'h011, 32'h0, lat, rd, er, wec, db, rc);
`ifdef LSU_MISALIGN_TRAP_EN
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL mis_lat: got %0d want 1", lat); end
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL mis_err: got %b want 1", er); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mis_rdata: got %h want 0", rd); end
    issue(1'b1, 2'b11, 1'b0, 12'h018, 32'h55555555, lat, rd, er, wec, db, rc);
    n_cmp++; if (wec !== 0) begin n_bad++; $display("FAIL rsv_we: got %0d want 0", wec); end
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL rsv_err: got %b want 1", er); end
`else
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL mis_lat: got %0d want 2", lat); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL mis_err: got %b want 0", er); end
    n_cmp++; if (rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL mis_rdata: got %h want cafef00d", rd); end
    issue(1'b1, 2'b11, 1'b0, 12'h018, 32'h55555555, lat, rd, er, wec, db, rc);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rsv_lat: got %0d want 2", lat); end
    n_cmp++; if (mem[6] !== 32'h55555555) begin n_bad++; $display("FAIL rsv_mem6: got %h want 55555555", mem[6]); end
`endif
  endtask

  task automatic test_back_to_back();
    int lat, wec, db, rc1, rc2; logic [31:0] rd; logic er;
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, lat, rd, er, wec, db, rc1);
    issue(1'b0, 2'b10, 1'b0, 12'h014, 32'h0, lat, rd, er, wec, db, rc2);
    n_cmp++; if (rc2 - rc1 !== 3) begin n_bad++; $display("FAIL b2b_spacing: got %0d want 3", rc2 - rc1); end
    n_cmp++; if (rd !== 32'h80F00000) begin n_bad++; $display("FAIL b2b_rdata: got %h want 80f00000", rd); end
  endtask

  task automatic test_reset_mid_rmw();
    int rsp_seen;
    rsp_seen = 0;
    set_word(10'd4, 32'h11223344);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 12'h012; bus.req_wdata = 32'h000000AA;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL rmw_rst_we: got %b want 0", we); end
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rmw_rst_ready: got %b want 1", bus.req_ready); end
    repeat (2) begin
      @(negedge clk);
      if (bus.rsp_valid) rsp_seen++;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid || we) rsp_seen++;
    end
    n_cmp++; if (rsp_seen !== 0) begin n_bad++; $display("FAIL rmw_rst_no_rsp: got %0d want 0", rsp_seen); end
    n_cmp++; if (mem[4] !== 32'h11223344) begin n_bad++; $display("FAIL rmw_rst_mem4: got %h want 11223344", mem[4]); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    test_reset();
    test_word_store_load();
    test_subword_store();
    test_extension();
    test_wrap();
    test_misalign();
    test_back_to_back();
    test_reset_mid_rmw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end
endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Load/store unit that drives the single-port `datamemory` block on behalf of the MIPS datapath. Accepts one byte-addressed load or store request at a time over a valid/ready handshake and converts it into word-wide memory accesses. Sub-word stores become read-modify-write sequences; loads return sign- or zero-extended data.

## Interface
Parameters:
- `ADDR_W`, 10: word-address width of the attached memory (1024 words of 32 bits).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- `req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0.
- `req_addr`  in  ADDR_W+2  byte address; `[ADDR_W+1:2]` is the word, `[1:0]` is the byte offset.
- `req_wdata`  in  32  store data, right-aligned (byte in `[7:0]`, halfword in `[15:0]`).
- `rsp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `rsp_rdata`  out  32  load result; valid only while `rsp_valid`=1, 0 otherwise.
- `rsp_err`  out  1  access rejected; valid with `rsp_valid`.
- `address`  out  ADDR_W  memory word address.
- `dataIn`  out  32  memory write data.
- `we`  out  1  memory write enable.
- `dataOut`  in  32  memory read data; registered read, i.e. reflects `mem[address]` sampled at the previous rising edge.

## Operation
- Byte lanes are little-endian: offset 0 = `[7:0]`, offset 2 = `[23:16]`; halfword at offset 0 = `[15:0]`, offset 2 = `[31:16]`.
- On `req_valid & req_ready` at a rising edge, latch write, size, unsigned, word address, offset and wdata.
- FSM states: IDLE, RD, WR, RSP.
  - IDLE: `req_ready`=1. Accepted load or sub-word store -> RD. Accepted word store -> WR. Rejected access (see Configuration) -> RSP.
  - RD: `address` = latched word, `we`=0. Load -> RSP. Sub-word store -> WR.
  - WR: `we`=1. `dataIn` = `req_wdata` for word stores. For sub-word stores, `dataIn` = `dataOut` with only the addressed byte or halfword lanes replaced from latched wdata -> RSP.
  - RSP: `rsp_valid`=1. For loads, `rsp_rdata` = lane extracted from `dataOut`, then extended per size/unsigned -> IDLE.
- `address` holds the latched word in every state, including IDLE after a transaction, so `dataOut` stays stable through RSP.
- `dataIn` = 0 whenever `we`=0.
- Stores return `rsp_rdata`=0.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `address`=0, `dataIn`=0, `we`=0.
- Latencies from the acceptance edge to the `rsp_valid` cycle (counted in cycles after acceptance):
  - Load: 2 cycles.
  - Word store: 2 cycles; memory written at the edge ending WR.
  - Sub-word store: 3 cycles.
  - Rejected access: 1 cycle.
- A new request can be accepted in the cycle after RSP at the earliest. Peak throughput is 1 load per 3 cycles.
- `req_valid` while `req_ready`=0 is ignored. The requester must hold the request until it is accepted.
- Reset asserted mid-operation: return to IDLE immediately and force `we` low asynchronously. An RMW interrupted in RD leaves memory unchanged. No response is issued for the aborted request.

## Configuration
- Macro `LSU_MISALIGN_TRAP_EN`.
- Defined: a halfword with `req_addr[0]`=1, a word with `req_addr[1:0]`≠0, or `req_size`=11 is rejected. The unit performs no memory access and goes IDLE->RSP with `rsp_err`=1 and `rsp_rdata`=0.
- Undefined: no access is rejected and `rsp_err` is tied to 0. Size 11 is treated as a word access. Halfword accesses ignore `req_addr[0]`; word accesses ignore `req_addr[1:0]`.

## Test plan
- Word store then load: store 0xDEADBEEF at byte addr 0x010, then load word at 0x010 -> memory word 4 = 0xDEADBEEF; `rsp_rdata`=0xDEADBEEF, with `rsp_valid` 2 cycles after each acceptance.
- Byte RMW: with word 4 = 0x11223344, store byte 0xAA at 0x012 -> word 4 = 0x11AA3344; `we` high for exactly 1 cycle; response 3 cycles after acceptance.
- Extension: word 5 = 0x0000F080. Signed byte load at 0x014 -> 0xFFFFFF80. Unsigned byte load at 0x014 -> 0x00000080. Signed halfword load at 0x014 -> 0xFFFFF080.
- Address wrap: word store 0x12345678 at byte 0xFFC, then load -> word 1023 written and read back; `address`=1023.
- Misalignment: word load at 0x011 -> with macro, `rsp_err`=1 after 1 cycle and `we` never asserts; without macro, returns word 4.
- Reset mid-RMW: assert `rst` during RD of a byte store to word 4 = 0x11223344 -> `we`=0, word 4 unchanged, `req_ready`=1, no `rsp_valid`.
